uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
// - Controller for the UART receive datapath; sits between the UART receiver and the CPU bus.
// - Generates the per-bit sample tick with a programmable baud divisor.
// - Buffers received bytes in a FIFO with overrun detection.
// - Exposes data, status, divisor and control registers to software; drives the RX interrupt.
// PARAMETERS
// - DataWidth   8    width of one received word
// - FifoDepth   8    RX FIFO entries; power of two, >= 2
// - DivWidth    16   width of baud divisor register
// - DivReset    867  divisor reset value (100 MHz / 115200 baud - 1)
// PORTS
// - clk_i      in   1          clock, all logic on rising edge
// - rst_i      in   1          reset, asynchronous, active-high
// - tick_o     out  1          one-cycle sample strobe to the receiver
// - rx_dv_i    in   1          receiver byte-valid; each high cycle = one byte
// - rx_data_i  in   DataWidth  received byte, valid when rx_dv_i=1
// - req_i      in   1          bus request, single cycle
// - we_i       in   1          1=write, 0=read (qualified by req_i)
// - addr_i     in   4          byte address; bits [1:0] ignored
// - wdata_i    in   32         write data
// - rdata_o    out  32         read data, registered
// - rvalid_o   out  1          rdata_o valid; 1 cycle after a read req_i
// - irq_o      out  1          interrupt, level
// BEHAVIOUR
// - Reset values (async on rst_i):
//   - tick_o=0, rdata_o=0, rvalid_o=0, irq_o=0
//   - FIFO empty, overrun=0, DIV=DivReset, CTRL.en=1, CTRL.irq_en=0, baud counter=0.
// - Register map (word index = addr_i[3:2]):
//   - 0x0 RXDATA (RO): read returns FIFO head, zero-extended, and pops it.
//   - 0x4 STATUS (RO):
//     - bit0 avail (!empty), bit1 full, bit2 overrun (sticky).
//     - bits[8+:CW] fill count, CW=$clog2(FifoDepth)+1; all other bits 0.
//   - 0x8 DIV (RW): low DivWidth bits; upper bits read 0.
//   - 0xC CTRL:
//     - bit0 en (RW), bit1 irq_en (RW).
//     - bit2 clr_ovr (W1, self-clearing), bit3 flush (W1, self-clearing); bits 2/3 read 0.
// - Writes to RXDATA/STATUS are ignored.
// - Baud tick generator:
//   - If en=0: counter held 0, tick_o=0.
//   - Else: counter increments each cycle; when counter==DIV, tick_o=1 that cycle and the counter returns to 0.
//     - Period is therefore DIV+1 cycles; DIV=0 gives tick_o high every cycle.
//   - A write to DIV clears the counter and forces tick_o=0 in the cycle after the write.
//   - Clearing en mid-count discards the partial count.
// - FIFO:
//   - Push when rx_dv_i=1 and en=1. Bytes arriving with en=0 are dropped silently (no overrun).
//   - Push when full is dropped, sets overrun, leaves contents unchanged.
//   - Simultaneous pop and push when full: both succeed, count unchanged, overrun not set.
//   - Pop of an empty FIFO returns 0 and has no effect on pointers or count.
//   - Pointers wrap modulo FifoDepth; count ranges 0..FifoDepth.
//   - Flush empties the FIFO in the write cycle; a push in the same cycle is discarded.
//   - Overrun set and clr_ovr in the same cycle: set wins.
// - Bus:
//   - Read at cycle N gives rdata_o/rvalid_o at N+1; rvalid_o=0 otherwise.
//   - rdata_o holds its last value when rvalid_o=0.
//   - RXDATA pop takes effect at cycle N; a STATUS read at N+1 reflects it.
//   - Back-to-back reads are supported, one per cycle.
// - Interrupt: irq_o = irq_en & (avail | overrun), registered (1 cycle after the cause).
// - Reset mid-operation: all state returns to the reset values; a pending rvalid is dropped.
// TESTING
// - Reset, then read DIV / CTRL / STATUS -> 867, 0x1, 0x0; tick_o first high at cycle 867 after reset release.
// - Write DIV=3 -> tick_o high every 4th cycle; write CTRL.en=0 -> tick_o stays 0; re-enable -> first tick 3 cycles later.
// - Push 0xA5,0x3C then read RXDATA twice -> 0xA5, 0x3C; third read returns 0 and STATUS=0.
// - Push 9 bytes with FifoDepth=8 -> STATUS full=1, overrun=1, count=8; 9th byte absent; clr_ovr -> overrun=0.
// - FIFO full, pop and push in the same cycle -> count stays 8, overrun=0, new byte read last.
// - irq_en=1 with one push -> irq_o=1 next cycle; pop -> irq_o=0; flush with a simultaneous push -> STATUS=0; async rst_i mid-read -> rvalid_o=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART RX bus controller with baud tick generator, RX FIFO with
// overrun detection, software register file and level interrupt.
module uart_rx_ctrl #(
   parameter int DataWidth = 8,
   parameter int FifoDepth = 8,
   parameter int DivWidth  = 16,
   parameter int DivReset  = 867
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   output logic                 tick_o,
   input  logic                 rx_dv_i,
   input  logic [DataWidth-1:0] rx_data_i,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [3:0]           addr_i,
   input  logic [31:0]          wdata_i,
   output logic [31:0]          rdata_o,
   output logic                 rvalid_o,
   output logic                 irq_o
);
   localparam int AW = $clog2(FifoDepth);
   localparam int CW = AW + 1;

   logic [DivWidth-1:0]  div_q, div_d, cnt_q, cnt_d;
   logic                 en_q, en_d, irq_en_q, irq_en_d, ovr_q, ovr_d;
   logic                 irq_q, irq_d, rvalid_q, div_wr_q;
   logic [AW-1:0]        rptr_q, rptr_d, wptr_q, wptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic [31:0]          rdata_q, rdata_d;
   logic [DataWidth-1:0] mem_q [FifoDepth];
   logic [1:0]           idx;
   logic                 rd, wr_div, wr_ctrl, flush, clr_ovr, empty, full;
   logic                 pop, push_req, push, match;
   logic                 unused_bits;

   assign unused_bits = ^{wdata_i[31:DivWidth], addr_i[1:0]};

   always_comb begin
      idx      = addr_i[3:2];
      rd       = req_i & ~we_i;
      wr_div   = req_i & we_i & (idx == 2'd2);
      wr_ctrl  = req_i & we_i & (idx == 2'd3);
      flush    = wr_ctrl & wdata_i[3];
      clr_ovr  = wr_ctrl & wdata_i[2];
      empty    = count_q == '0;
      full     = count_q == CW'(FifoDepth);
      pop      = rd & (idx == 2'd0) & ~empty;
      push_req = rx_dv_i & en_q & ~flush;
      push     = push_req & (~full | pop);
      en_d     = wr_ctrl ? wdata_i[0] : en_q;
      irq_en_d = wr_ctrl ? wdata_i[1] : irq_en_q;
      div_d    = wr_div ? wdata_i[DivWidth-1:0] : div_q;
      match    = en_q & (cnt_q == div_q);
      // Counter restarts on disable, enable edge, divisor write or wrap.
      cnt_d    = (~en_q | ~en_d | wr_div | match) ? '0 : cnt_q + 1'b1;
      rptr_d   = flush ? '0 : rptr_q + AW'(pop);
      wptr_d   = flush ? '0 : wptr_q + AW'(push);
      count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
      ovr_d    = (push_req & full & ~pop) | (ovr_q & ~clr_ovr);
      irq_d    = irq_en_d & ((count_d != '0) | ovr_d);
      rdata_d  = ~rd           ? rdata_q :
                 idx == 2'd0   ? (empty ? '0 : 32'(mem_q[rptr_q])) :
                 idx == 2'd1   ? 32'({count_q, 5'b0, ovr_q, full, ~empty}) :
                 idx == 2'd2   ? 32'(div_q) : {30'b0, irq_en_q, en_q};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q    <= DivWidth'(DivReset);
         cnt_q    <= '0;
         en_q     <= 1'b1;
         irq_en_q <= 1'b0;
         ovr_q    <= 1'b0;
         irq_q    <= 1'b0;
         rvalid_q <= 1'b0;
         div_wr_q <= 1'b0;
         rptr_q   <= '0;
         wptr_q   <= '0;
         count_q  <= '0;
         rdata_q  <= '0;
      end else begin
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         ovr_q    <= ovr_d;
         irq_q    <= irq_d;
         rvalid_q <= rd;
         div_wr_q <= wr_div;
         rptr_q   <= rptr_d;
         wptr_q   <= wptr_d;
         count_q  <= count_d;
         rdata_q  <= rdata_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem_q[wptr_q] <= rx_data_i;
   end

   assign tick_o   = match & ~div_wr_q;
   assign rdata_o  = rdata_q;
   assign rvalid_o = rvalid_q;
   assign irq_o    = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed-vector bench for uart_rx_ctrl with hand-computed expectations.
module tb_uart_rx_ctrl;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        tick_o, rx_dv_i = 1'b0, req_i = 1'b0, we_i = 1'b0;
   logic [7:0]  rx_data_i = '0;
   logic [3:0]  addr_i = '0;
   logic [31:0] wdata_i = '0, rdata_o;
   logic        rvalid_o, irq_o;
   int          n_vec = 0, n_err = 0;

   uart_rx_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i), .tick_o(tick_o), .rx_dv_i(rx_dv_i),
      .rx_data_i(rx_data_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .irq_o(irq_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
      step();
      req_i = 1'b0; we_i = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
      req_i = 1'b1; we_i = 1'b0; addr_i = a;
      step();
      req_i = 1'b0;
      check({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
      check(tag, rdata_o, exp);
   endtask

   task automatic push(input logic [7:0] b);
      rx_dv_i = 1'b1; rx_data_i = b;
      step();
      rx_dv_i = 1'b0;
   endtask

   task automatic tick_pattern(input string tag, input logic [7:0] exp);
      logic [7:0] obs;
      obs[0] = tick_o;
      for (int j = 1; j < 8; j++) begin
         step();
         obs[j] = tick_o;
      end
      check(tag, 32'(obs), 32'(exp));
   endtask

   initial begin
      int first;
      repeat (2) @(negedge clk_i);
      check("rst_tick", 32'(tick_o), 32'd0);
      check("rst_rvalid", 32'(rvalid_o), 32'd0);
      check("rst_irq", 32'(irq_o), 32'd0);
      check("rst_rdata", rdata_o, 32'd0);
      rst_i = 1'b0;
      first = 0;
      for (int i = 1; i <= 900 && first == 0; i++) begin
         step();
         if (tick_o) first = i;
      end
      check("first_tick", 32'(first), 32'd867);
      rd("rst_div", 4'h8, 32'd867);
      rd("rst_ctrl", 4'hC, 32'h1);
      rd("rst_status", 4'h4, 32'h0);

      wr(4'h8, 32'd3);
      tick_pattern("div3_ticks", 8'h88);
      wr(4'hC, 32'h0);
      tick_pattern("dis_ticks", 8'h00);
      wr(4'hC, 32'h1);
      tick_pattern("reen_ticks", 8'h88);

      push(8'hA5);
      push(8'h3C);
      rd("rx0", 4'h0, 32'hA5);
      rd("rx1", 4'h0, 32'h3C);
      rd("rx_empty", 4'h0, 32'h0);
      rd("st_empty", 4'h4, 32'h0);

      for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
      rd("st_ovr", 4'h4, 32'h807);
      wr(4'hC, 32'h5);
      rd("st_clr", 4'h4, 32'h803);

      req_i = 1'b1; we_i = 1'b0; addr_i = 4'h0; rx_dv_i = 1'b1; rx_data_i = 8'h99;
      step();
      req_i = 1'b0; rx_dv_i = 1'b0;
      check("popush_data", rdata_o, 32'h10);
      rd("st_popush", 4'h4, 32'h803);
      for (int i = 0; i < 8; i++) rd("drain", 4'h0, (i < 7) ? 32'(8'h11 + i) : 32'h99);
      rd("st_drained", 4'h4, 32'h0);

      wr(4'hC, 32'h3);
      check("irq_idle", 32'(irq_o), 32'd0);
      push(8'h42);
      check("irq_push", 32'(irq_o), 32'd1);
      rd("irq_pop_data", 4'h0, 32'h42);
      check("irq_pop", 32'(irq_o), 32'd0);
      push(8'h55);
      rx_dv_i = 1'b1; rx_data_i = 8'h66;
      wr(4'hC, 32'hB);
      rx_dv_i = 1'b0;
      check("irq_flush", 32'(irq_o), 32'd0);
      rd("st_flush", 4'h4, 32'h0);
      rd("ctrl_flush", 4'hC, 32'h3);

      req_i = 1'b1; we_i = 1'b0; addr_i = 4'h8;
      @(posedge clk_i);
      #1;
      req_i = 1'b0;
      check("pre_rst_rvalid", 32'(rvalid_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check("async_rvalid", 32'(rvalid_o), 32'd0);
      check("async_rdata", rdata_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      rd("post_rst_div", 4'h8, 32'd867);
      rd("post_rst_ctrl", 4'hC, 32'h1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
